// File: rtl/hazard_sched_if.sv
// rtl/hazard_sched_if.sv - pipeline hazard sequencer signal bundle (decoder side = master, sequencer = slave)
interface hazard_sched_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mdu;
    logic        ex_redirect;
    logic [1:0]  ex_sys;
    logic        mdu_done;
    logic        resume;

    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_bubble;
    logic        exmem_bubble;
    logic        ifid_flush;
    logic        idex_flush;
    logic        mdu_start;
    logic        halted;
    logic        mdu_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs2, ex_rd, ex_mem_read, ex_mdu,
               ex_redirect, ex_sys, mdu_done, resume,
        input  pc_stall, ifid_stall, idex_bubble, exmem_bubble, ifid_flush,
               idex_flush, mdu_start, halted, mdu_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs2, ex_rd, ex_mem_read, ex_mdu,
               ex_redirect, ex_sys, mdu_done, resume,
        output pc_stall, ifid_stall, idex_bubble, exmem_bubble, ifid_flush,
               idex_flush, mdu_start, halted, mdu_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - stall/bubble/flush sequencer for the 5-stage core; HAZARD_SCHED_PERF_EN enables the stall counter
module hazard_sched #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MDU_TIMEOUT  = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    hazard_sched_if.slave bus
);
    typedef enum logic [1:0] {S_RUN, S_MDU_WAIT, S_DRAIN, S_HALT} state_t;

    localparam logic [1:0] SYS_FENCE = 2'b01;

    state_t     r_state;
    logic [3:0] r_drain_cnt;
    logic [1:0] r_sys_kind;
    logic [9:0] r_tmo_cnt;
    logic       r_lu_seen;
    logic       r_mdu_start;
    logic       r_mdu_timeout;

    logic w_load_use;
    logic w_lu_stall;
    logic w_tmo_hit;
    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_idex_bubble;
    logic w_exmem_bubble;
    logic w_ifid_flush;
    logic w_idex_flush;

    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.ex_rd == bus.id_rs1) ||
                         (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));

    // Load-use only fires when nothing of higher priority is present; r_lu_seen
    // keeps a held pattern from stretching the stall past one cycle.
    assign w_lu_stall = (r_state == S_RUN) && !bus.ex_redirect &&
                        (bus.ex_sys == 2'b00) && !bus.ex_mdu &&
                        w_load_use && !r_lu_seen;

    assign w_tmo_hit = (r_tmo_cnt == 10'(MDU_TIMEOUT - 1));

    // Stall/bubble/flush decode from current state and EX/ID inputs, silenced during reset
    always_comb begin
        w_pc_stall     = 1'b0;
        w_ifid_stall   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_RUN: begin
                    if (bus.ex_redirect) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (bus.ex_sys != 2'b00) begin
                        w_pc_stall   = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_lu_stall) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end
                end
                S_MDU_WAIT: begin
                    if (!bus.mdu_done && !w_tmo_hit) begin
                        w_pc_stall     = 1'b1;
                        w_ifid_stall   = 1'b1;
                        w_exmem_bubble = 1'b1;
                    end
                end
                S_DRAIN: begin
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                end
                S_HALT: begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, drain/timeout counters and registered mdu_start / timeout flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_drain_cnt   <= 4'd0;
            r_sys_kind    <= 2'b00;
            r_tmo_cnt     <= 10'd0;
            r_lu_seen     <= 1'b0;
            r_mdu_start   <= 1'b0;
            r_mdu_timeout <= 1'b0;
        end else begin
            r_mdu_start <= 1'b0;
            r_lu_seen   <= w_lu_stall;
            case (r_state)
                S_RUN: begin
                    if (bus.ex_redirect) begin
                        r_state <= S_RUN;
                    end else if (bus.ex_sys != 2'b00) begin
                        r_drain_cnt <= 4'(DRAIN_CYCLES);
                        r_sys_kind  <= bus.ex_sys;
                        r_state     <= S_DRAIN;
                    end else if (bus.ex_mdu) begin
                        r_tmo_cnt   <= 10'd0;
                        r_mdu_start <= 1'b1;
                        r_state     <= S_MDU_WAIT;
                    end
                end
                S_MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        r_state <= S_RUN;
                    end else if (w_tmo_hit) begin
                        r_mdu_timeout <= 1'b1;
                        r_state       <= S_RUN;
                    end else if (r_tmo_cnt != 10'h3FF) begin
                        r_tmo_cnt <= r_tmo_cnt + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt <= 4'd1) begin
                        r_state <= (r_sys_kind == SYS_FENCE) ? S_RUN : S_HALT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                    end
                end
                S_HALT: begin
                    if (bus.resume) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef HAZARD_SCHED_PERF_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= 32'd0;
        end else if (w_pc_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = 32'd0;
`endif

    assign bus.pc_stall     = w_pc_stall;
    assign bus.ifid_stall   = w_ifid_stall;
    assign bus.idex_bubble  = w_idex_bubble;
    assign bus.exmem_bubble = w_exmem_bubble;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.mdu_start    = r_mdu_start;
    assign bus.halted       = (r_state == S_HALT);
    assign bus.mdu_timeout  = r_mdu_timeout;
endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - scoreboard bench for hazard_sched
module tb_hazard_sched;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_sched_if u_if ();

    hazard_sched u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    localparam logic [8:0] PC  = 9'h100;
    localparam logic [8:0] IS  = 9'h080;
    localparam logic [8:0] IB  = 9'h040;
    localparam logic [8:0] EB  = 9'h020;
    localparam logic [8:0] IFF = 9'h010;
    localparam logic [8:0] IDF = 9'h008;
    localparam logic [8:0] MS  = 9'h004;
    localparam logic [8:0] HL  = 9'h002;
    localparam logic [8:0] TO  = 9'h001;
    localparam logic [8:0] LU  = PC | IS | IB;
    localparam logic [8:0] MW  = PC | IS | EB;

    typedef struct {
        string       tag;
        logic [8:0]  ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cnt_model = 32'd0;
    logic [8:0]  obs_ctl;

    assign obs_ctl = {u_if.pc_stall, u_if.ifid_stall, u_if.idex_bubble, u_if.exmem_bubble,
                      u_if.ifid_flush, u_if.idex_flush, u_if.mdu_start, u_if.halted,
                      u_if.mdu_timeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rst                = 1'b0;
        u_if.id_rs1        = 5'd0;
        u_if.id_rs2        = 5'd0;
        u_if.id_use_rs2    = 1'b0;
        u_if.ex_rd         = 5'd0;
        u_if.ex_mem_read   = 1'b0;
        u_if.ex_mdu        = 1'b0;
        u_if.ex_redirect   = 1'b0;
        u_if.ex_sys        = 2'b00;
        u_if.mdu_done      = 1'b0;
        u_if.resume        = 1'b0;
    endtask

    // Inputs for this cycle are already applied; record the expectation, then advance.
    task automatic step(input string tag, input logic [8:0] ctl);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
`ifdef HAZARD_SCHED_PERF_EN
        e.cnt = cnt_model;
        if (rst) cnt_model = 32'd0;
        else if (ctl[8]) cnt_model = cnt_model + 32'd1;
`else
        e.cnt = 32'd0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, ":ctl"}, 32'(obs_ctl), 32'(mon_e.ctl));
            check({mon_e.tag, ":cnt"}, u_if.stall_cycles, mon_e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog no_finish got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("reset", 9'h000);
        step("idle", 9'h000);

        u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd5; u_if.id_rs1 = 5'd5;
        step("lu_rs1", LU);
        u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd5; u_if.id_rs1 = 5'd5;
        step("lu_once", 9'h000);
        step("idle2", 9'h000);

        u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd7; u_if.id_rs2 = 5'd7;
        u_if.id_use_rs2 = 1'b1; u_if.id_rs1 = 5'd3;
        step("lu_rs2", LU);
        u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd0; u_if.id_rs1 = 5'd0;
        step("lu_x0", 9'h000);
        u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd7; u_if.id_rs2 = 5'd7; u_if.id_rs1 = 5'd2;
        step("lu_rs2_unused", 9'h000);
        u_if.ex_redirect = 1'b1; u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd5; u_if.id_rs1 = 5'd5;
        step("redir_lu", IFF | IDF);

        u_if.ex_mdu = 1'b1;
        step("mdu_issue", 9'h000);
        step("mdu_w1", MW | MS);
        step("mdu_w2", MW);
        step("mdu_w3", MW);
        step("mdu_w4", MW);
        u_if.mdu_done = 1'b1;
        step("mdu_done", 9'h000);
        step("mdu_run", 9'h000);

        u_if.ex_mdu = 1'b1;
        step("mdu0_issue", 9'h000);
        u_if.mdu_done = 1'b1;
        step("mdu0_done", MS);
        step("mdu0_run", 9'h000);

        u_if.ex_redirect = 1'b1; u_if.ex_mdu = 1'b1;
        step("redir_mdu", IFF | IDF);
        step("redir_mdu_run", 9'h000);

        u_if.ex_mdu = 1'b1;
        step("tmo_issue", 9'h000);
        step("tmo_w0", MW | MS);
        for (int i = 0; i < 62; i++) step("tmo_wait", MW);
        step("tmo_hit", 9'h000);
        step("tmo_flag", TO);

        u_if.ex_sys = 2'b10;
        step("ecall", PC | IFF | IDF | TO);
        step("ecall_d1", PC | IFF | TO);
        u_if.ex_redirect = 1'b1; u_if.ex_mdu = 1'b1; u_if.resume = 1'b1;
        step("ecall_d2", PC | IFF | TO);
        step("ecall_d3", PC | IFF | TO);
        step("halt1", LU | HL | TO);
        step("halt2", LU | HL | TO);
        u_if.resume = 1'b1;
        step("halt_resume", LU | HL | TO);
        step("resumed", TO);

        u_if.ex_sys = 2'b01;
        step("fence", PC | IFF | IDF | TO);
        step("fence_d1", PC | IFF | TO);
        step("fence_d2", PC | IFF | TO);
        step("fence_d3", PC | IFF | TO);
        step("fence_run", TO);

        u_if.ex_mdu = 1'b1;
        step("rmid_issue", TO);
        step("rmid_w1", MW | MS | TO);
        rst = 1'b1; u_if.mdu_done = 1'b0;
        step("rmid_rst", TO);
        step("rmid_after", 9'h000);
        step("rmid_idle", 9'h000);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
